// File: rtl/delay_meas_pkg.sv
// Shared types for the delay measurement receiver: report classes, canonical
// line-state encodings ({drv, drv&val}) and FSM state codes.
package delay_meas_pkg;

  typedef enum logic [2:0] {
    RISE = 3'd0,
    FALL = 3'd1,
    OFF  = 3'd2,
    ON0  = 3'd3,
    ON1  = 3'd4,
    TMO  = 3'd5
  } dm_class_t;

  localparam logic [1:0] LINE_Z = 2'b00;
  localparam logic [1:0] LINE_0 = 2'b10;
  localparam logic [1:0] LINE_1 = 2'b11;

  typedef logic [1:0] dm_state_t;

  localparam dm_state_t IDLE    = 2'd0;
  localparam dm_state_t MEASURE = 2'd1;
  localparam dm_state_t REPORT  = 2'd2;

endpackage

// File: rtl/delay_meas_rx_classify.sv
// Combinational line transition classifier: flags a change of the canonical
// line state and names the transition.
module line_edge_classify
  import delay_meas_pkg::*;
(
  input  logic [1:0] prev_line,
  input  logic [1:0] cur_line,
  output logic       changed,
  output dm_class_t  cls
);

  // Map (previous, current) line state to a change flag and a class.
  always_comb begin
    changed = (cur_line != prev_line);
    cls     = RISE;
    case ({prev_line, cur_line})
      {LINE_0, LINE_1}: cls = RISE;
      {LINE_1, LINE_0}: cls = FALL;
      {LINE_0, LINE_Z},
      {LINE_1, LINE_Z}: cls = OFF;
      {LINE_Z, LINE_0}: cls = ON0;
      {LINE_Z, LINE_1}: cls = ON1;
      default:          cls = RISE;
    endcase
  end

endmodule

// File: rtl/delay_meas_rx.sv
// Stimulus-to-line delay measurement with valid/ready report output.
// Optional min/max statistics are built when DELAY_MEAS_STATS_EN is defined.
module delay_meas_rx
  import delay_meas_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stim,
  input  logic             line_val,
  input  logic             line_drv,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [2:0]       rpt_class,
  output logic [CNT_W-1:0] rpt_delay,
  output logic             busy,
  output logic             drop,
  output logic             spur,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_min,
  output logic [CNT_W-1:0] stat_max
);

  if (TIMEOUT < 1 || TIMEOUT > (2**CNT_W) - 1) begin : g_timeout_range
    $error("delay_meas_rx: TIMEOUT must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_DLY  = CNT_W'(TIMEOUT);

  logic             stim_prev_r;
  logic [1:0]       line_prev_r;
  logic [1:0]       line_cur_s;
  logic             line_chg_s;
  dm_class_t        line_cls_s;
  logic             stim_edge_s;
  logic             accept_s;

  dm_state_t        state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [CNT_W-1:0] dly_r, dly_nx_s;
  dm_class_t        cls_r, cls_nx_s;
  logic             drop_r, drop_nx_s;
  logic             spur_r, spur_nx_s;
  logic             valid_r;
  logic             busy_r;

  assign line_cur_s  = {line_drv, line_drv & line_val};
  assign stim_edge_s = (stim != stim_prev_r);
  assign accept_s    = (state_r == REPORT) & rpt_ready;

  line_edge_classify u_classify (
    .prev_line (line_prev_r),
    .cur_line  (line_cur_s),
    .changed   (line_chg_s),
    .cls       (line_cls_s)
  );

  // Next-state logic; a counter of k-1 in MEASURE means k cycles since the edge.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    cls_nx_s   = cls_r;
    dly_nx_s   = dly_r;
    drop_nx_s  = 1'b0;
    spur_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (stim_edge_s) begin
          if (line_chg_s) begin
            state_nx_s = REPORT;
            cls_nx_s   = line_cls_s;
            dly_nx_s   = ZERO;
          end else begin
            state_nx_s = MEASURE;
            cnt_nx_s   = ZERO;
          end
        end else if (line_chg_s) begin
          spur_nx_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MEASURE: begin
        if (line_chg_s) begin
          state_nx_s = REPORT;
          cls_nx_s   = line_cls_s;
          dly_nx_s   = cnt_r + ONE;
        end else if (stim_edge_s) begin
          cnt_nx_s = ZERO;
        end else if (cnt_r == TMO_LAST) begin
          state_nx_s = REPORT;
          cls_nx_s   = TMO;
          dly_nx_s   = TMO_DLY;
        end else begin
          cnt_nx_s = cnt_r + ONE;
        end
      end
      REPORT: begin
        drop_nx_s = stim_edge_s;
        if (accept_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = REPORT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, counter, edge history and registered report outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= ZERO;
      dly_r       <= ZERO;
      cls_r       <= RISE;
      drop_r      <= 1'b0;
      spur_r      <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      stim_prev_r <= 1'b0;
      line_prev_r <= LINE_Z;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      dly_r       <= dly_nx_s;
      cls_r       <= cls_nx_s;
      drop_r      <= drop_nx_s;
      spur_r      <= spur_nx_s;
      valid_r     <= (state_nx_s == REPORT);
      busy_r      <= (state_nx_s != IDLE);
      stim_prev_r <= stim;
      line_prev_r <= line_cur_s;
    end
  end

  assign rpt_valid = valid_r;
  assign rpt_class = cls_r;
  assign rpt_delay = dly_r;
  assign busy      = busy_r;
  assign drop      = drop_r;
  assign spur      = spur_r;

`ifdef DELAY_MEAS_STATS_EN
  logic [CNT_W-1:0] stat_min_r;
  logic [CNT_W-1:0] stat_max_r;

  // Min/max of accepted non-timeout delays; a clear wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_min_r <= {CNT_W{1'b1}};
      stat_max_r <= ZERO;
    end else if (stat_clr) begin
      stat_min_r <= {CNT_W{1'b1}};
      stat_max_r <= ZERO;
    end else if (accept_s && (cls_r != TMO)) begin
      if (dly_r < stat_min_r) stat_min_r <= dly_r;
      if (dly_r > stat_max_r) stat_max_r <= dly_r;
    end
  end

  assign stat_min = stat_min_r;
  assign stat_max = stat_max_r;
`else
  logic unused_stat_clr_s;

  assign unused_stat_clr_s = stat_clr;
  assign stat_min          = ZERO;
  assign stat_max          = ZERO;
`endif

endmodule

// File: tb/tb_delay_meas_rx.sv
// Self-checking bench for delay_meas_rx: scoreboard of expected reports plus
// per-scenario inline checks of handshake, drop/spur pulses, reset and stats.
module tb_delay_meas_rx;
  import delay_meas_pkg::*;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;
`ifdef DELAY_MEAS_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif
  localparam logic [7:0] MIN_RST = STATS_ON ? 8'hFF : 8'h00;

  logic clk = 1'b0;
  logic rst, stim, line_val, line_drv, rpt_ready, stat_clr;
  logic       rpt_valid, busy, drop, spur;
  logic [2:0] rpt_class;
  logic [7:0] rpt_delay, stat_min, stat_max;

  typedef struct packed {
    logic [2:0] cls;
    logic [7:0] dly;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  delay_meas_rx #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .stim(stim), .line_val(line_val), .line_drv(line_drv),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_class(rpt_class),
    .rpt_delay(rpt_delay), .busy(busy), .drop(drop), .spur(spur),
    .stat_clr(stat_clr), .stat_min(stat_min), .stat_max(stat_max)
  );

  always #5 clk = ~clk;

  // Pop and compare one expected report per handshake.
  always @(negedge clk) begin
    if (!rst && rpt_valid && rpt_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_report: got class %0d delay %0d, required no report", rpt_class, rpt_delay);
      end else begin
        mon_e = sb_q.pop_front();
        if ({rpt_class, rpt_delay} !== {mon_e.cls, mon_e.dly}) begin
          miscompares++;
          $display("FAIL report: got class %0d delay %0d, required class %0d delay %0d",
                   rpt_class, rpt_delay, mon_e.cls, mon_e.dly);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input dm_class_t c, input int d);
    sb_q.push_back('{cls: c, dly: 8'(d)});
  endtask

  // Edge, d cycles later line change to (nd,nv), then one handshake cycle.
  task automatic meas(input int d, input logic nd, input logic nv, input dm_class_t c);
    push(c, d);
    stim = ~stim;
    if (d == 0) begin line_drv = nd; line_val = nv; end
    step();
    for (int i = 1; i <= d; i++) begin
      if (i == d) begin line_drv = nd; line_val = nv; end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; stim = 1'b0; line_drv = 1'b0; line_val = 1'b0;
    rpt_ready = 1'b1; stat_clr = 1'b0;
    step(); step();
    vectors++;
    if ({rpt_valid, rpt_class, rpt_delay, busy, drop, spur, stat_min, stat_max} !==
        {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, MIN_RST, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h, required %h",
               {rpt_valid, rpt_class, rpt_delay, busy, drop, spur, stat_min, stat_max},
               {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, MIN_RST, 8'd0});
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({busy, spur, rpt_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b, required 000", {busy, spur, rpt_valid});
    end
  endtask

  task automatic test_rise();
    line_drv = 1'b1; line_val = 1'b0;
    step();
    vectors++;
    if (spur !== 1'b1) begin
      miscompares++; $display("FAIL spur_z_to_0: got %b, required 1", spur);
    end
    step();
    stim = 1'b1;
    step();
    vectors++;
    if ({busy, rpt_valid, spur} !== 3'b100) begin
      miscompares++; $display("FAIL measure_entry: got %b, required 100", {busy, rpt_valid, spur});
    end
    step();
    line_val = 1'b1; push(RISE, 2);
    step();
    vectors++;
    if (rpt_valid !== 1'b1) begin
      miscompares++; $display("FAIL rise_valid: got %b, required 1", rpt_valid);
    end
    step();
    vectors++;
    if ({rpt_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL rise_one_cycle: got %b, required 00", {rpt_valid, busy});
    end
  endtask

  task automatic test_off_hold();
    rpt_ready = 1'b0;
    stim = 1'b0;
    step();
    repeat (6) step();
    line_drv = 1'b0; push(OFF, 7);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) stim = 1'b1;
      step();
      vectors++;
      if ({rpt_valid, rpt_class, rpt_delay} !== {1'b1, 3'(OFF), 8'd7}) begin
        miscompares++;
        $display("FAIL off_hold[%0d]: got v=%b class %0d delay %0d, required v=1 class 2 delay 7",
                 i, rpt_valid, rpt_class, rpt_delay);
      end
      vectors++;
      if (drop !== (i == 1)) begin
        miscompares++; $display("FAIL drop[%0d]: got %b, required %b", i, drop, (i == 1));
      end
    end
    rpt_ready = 1'b1;
    step();
    vectors++;
    if ({rpt_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL off_release: got %b, required 00", {rpt_valid, busy});
    end
  endtask

  task automatic test_timeout();
    int n;
    push(TMO, TIMEOUT);
    stim = 1'b0;
    step();
    n = 0;
    while (rpt_valid !== 1'b1 && n < 260) begin
      step();
      n++;
    end
    vectors++;
    if (n != TIMEOUT) begin
      miscompares++; $display("FAIL timeout_cycles: got %0d, required %0d", n, TIMEOUT);
    end
    step();
    vectors++;
    if (rpt_valid !== 1'b0) begin
      miscompares++; $display("FAIL timeout_release: got %b, required 0", rpt_valid);
    end
  endtask

  task automatic test_restart_and_spur();
    stim = 1'b1;
    step(); step(); step();
    stim = 1'b0;
    step(); step();
    line_drv = 1'b1; line_val = 1'b1; push(ON1, 2);
    step();
    vectors++;
    if (rpt_valid !== 1'b1) begin
      miscompares++; $display("FAIL restart_valid: got %b, required 1", rpt_valid);
    end
    step();
    line_val = 1'b0;
    step();
    vectors++;
    if ({spur, rpt_valid, busy} !== 3'b100) begin
      miscompares++; $display("FAIL idle_spur: got %b, required 100", {spur, rpt_valid, busy});
    end
    step();
    vectors++;
    if (spur !== 1'b0) begin
      miscompares++; $display("FAIL spur_pulse_width: got %b, required 0", spur);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    stim = 1'b1; line_val = 1'b1; push(RISE, 0);
    step();
    vectors++;
    if ({rpt_valid, rpt_delay} !== {1'b1, 8'd0}) begin
      miscompares++; $display("FAIL zero_delay: got v=%b delay %0d, required v=1 delay 0", rpt_valid, rpt_delay);
    end
    step();
    stim = 1'b0;
    step(); step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_busy: got %b, required 1", busy);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({rpt_valid, rpt_class, rpt_delay, busy, drop, spur, stat_min, stat_max} !==
        {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, MIN_RST, 8'd0}) begin
      miscompares++;
      $display("FAIL mid_reset_state: got %h, required %h",
               {rpt_valid, rpt_class, rpt_delay, busy, drop, spur, stat_min, stat_max},
               {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, MIN_RST, 8'd0});
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({spur, busy, rpt_valid} !== 3'b100) begin
      miscompares++; $display("FAIL post_reset_spur: got %b, required 100", {spur, busy, rpt_valid});
    end
    repeat (3) step();
    vectors++;
    if ({busy, rpt_valid} !== 2'b00) begin
      miscompares++; $display("FAIL no_report_after_reset: got %b, required 00", {busy, rpt_valid});
    end
  endtask

  task automatic test_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    meas(4, 1'b0, 1'b0, OFF);
    meas(9, 1'b1, 1'b0, ON0);
    meas(2, 1'b1, 1'b1, RISE);
    vectors++;
    if ({stat_min, stat_max} !== (STATS_ON ? {8'd2, 8'd9} : 16'd0)) begin
      miscompares++; $display("FAIL stats_minmax: got min %0d max %0d", stat_min, stat_max);
    end
    push(TMO, TIMEOUT);
    stim = ~stim;
    step();
    repeat (TIMEOUT) step();
    step();
    vectors++;
    if ({stat_min, stat_max} !== (STATS_ON ? {8'd2, 8'd9} : 16'd0)) begin
      miscompares++; $display("FAIL stats_after_tmo: got min %0d max %0d", stat_min, stat_max);
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    vectors++;
    if ({stat_min, stat_max} !== {MIN_RST, 8'd0}) begin
      miscompares++;
      $display("FAIL stats_clear: got min %0d max %0d, required min %0d max 0", stat_min, stat_max, MIN_RST);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_off_hold();
    test_timeout();
    test_restart_and_spur();
    test_same_cycle_and_reset();
    test_stats();
    step();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
